imem_uart_loader: RTL and testbench

- Serial boot loader that sits directly upstream of the instruction memory and the RV32I core.
- Receives a framed program image over an 8N1 UART line and assembles little-endian 32-bit words.
- Writes each word through the imem write port.
- Holds the core in reset until the image is complete, then releases it.

---
 rtl/imem_uart_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// imem_uart_loader
//   Serial boot loader placed in front of the instruction memory and the
//   RV32I core. An 8N1 UART byte stream carrying a framed program image is
//   turned into 32-bit little-endian words, which are written into imem.
//   The core is held in reset until the whole image has landed.
//
//   Frame: 0xA5, LEN_LO, LEN_HI, then 4*LEN data bytes (LSB byte first).
//
//   Handshake: imemWE is a single-cycle strobe. imemAdrs/imemWD are valid
//   in the strobe cycle and hold their values afterwards; there is no
//   back-pressure, so imem must accept a write every strobe.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx           asynchronous UART line, idle high
//   imemWE       one-cycle instruction-memory write strobe
//   imemAdrs     word-aligned byte address of the word being written
//   imemWD       instruction word being written
//   coreReset    core reset, high until the image is complete
//   loading      high from sync byte accepted until DONE
//   done         high while the image is complete
//   error        sticky framing / bad-length flag, cleared only by reset
//   rxStateDbg   bit-receiver state, for observation only
//   byteStateDbg frame-parser state, for observation only
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imemWE,
  output logic [31:0] imemAdrs,
  output logic [31:0] imemWD,
  output logic        coreReset,
  output logic        loading,
  output logic        done,
  output logic        error,
  output logic [1:0]  rxStateDbg,
  output logic [2:0]  byteStateDbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   MAX_LEN   = 17'(MAX_WORDS);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------------
  // rx synchronizer (idle high so reset does not fake a start bit)
  // ---------------------------------------------------------------------
  logic rxMeta;
  logic rxSync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
    end
  end

  // ---------------------------------------------------------------------
  // Bit receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rxState_t;

  rxState_t       rxState;
  rxState_t       rxNext;
  logic [CW-1:0]  bitTimer;
  logic [2:0]     bitIdx;
  logic [7:0]     shiftReg;
  logic           sampleNow;
  logic           byteValid;
  logic           frameErr;

  // The start bit is checked half a bit in; every later sample is one
  // full bit period after the previous one, i.e. mid-bit.
  always_comb begin
    sampleNow = 1'b0;
    if (rxState == RX_START)
      sampleNow = (bitTimer == HALF_LAST);
    else if (rxState != RX_IDLE)
      sampleNow = (bitTimer == BIT_LAST);
  end

  always_comb begin
    rxNext = rxState;
    unique case (rxState)
      RX_IDLE:  if (!rxSync) rxNext = RX_START;
      RX_START: if (sampleNow) rxNext = rxSync ? RX_IDLE : RX_BITS;
      RX_BITS:  if (sampleNow && bitIdx == 3'd7) rxNext = RX_STOP;
      RX_STOP:  if (sampleNow) rxNext = RX_IDLE;
      default:  rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxState <= RX_IDLE;
    end else begin
      rxState <= rxNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitTimer  <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
      if (rxState == RX_IDLE || sampleNow)
        bitTimer <= '0;
      else
        bitTimer <= bitTimer + 1'b1;
      if (rxState == RX_START && sampleNow)
        bitIdx <= '0;
      if (rxState == RX_BITS && sampleNow) begin
        shiftReg <= {rxSync, shiftReg[7:1]};
        bitIdx   <= bitIdx + 1'b1;
      end
      if (rxState == RX_STOP && sampleNow) begin
        byteValid <= rxSync;
        frameErr  <= !rxSync;
      end
    end
  end

  // shiftReg is untouched until the next byte's data bits, so it is a
  // stable byte value during the byteValid pulse.
  logic [7:0] rxByte;
  assign rxByte = shiftReg;

  // ---------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE
  } byteState_t;

  byteState_t  byteState;
  byteState_t  byteNext;
  logic [7:0]  lenLo;
  logic [15:0] lenWords;
  logic [15:0] lenFull;
  logic [15:0] wordIdx;
  logic [1:0]  byteCnt;
  logic [23:0] wordBuf;
  logic        finishPending;

  assign lenFull = {rxByte, lenLo};

  always_comb begin
    byteNext = byteState;
    if (frameErr) begin
      // A broken byte aborts an in-progress load; idle/done states ignore it.
      if (byteState == S_LEN_LO || byteState == S_LEN_HI || byteState == S_DATA)
        byteNext = S_WAIT_SYNC;
    end else if (byteValid) begin
      unique case (byteState)
        S_WAIT_SYNC, S_DONE: if (rxByte == SYNC_BYTE) byteNext = S_LEN_LO;
        S_LEN_LO:            byteNext = S_LEN_HI;
        S_LEN_HI: begin
          if (lenFull == 16'd0)
            byteNext = S_DONE;
          else if ({1'b0, lenFull} > MAX_LEN)
            byteNext = S_WAIT_SYNC;
          else
            byteNext = S_DATA;
        end
        S_DATA:              byteNext = S_DATA;
        default:             byteNext = S_WAIT_SYNC;
      endcase
    end else if (byteState == S_DATA && finishPending) begin
      // finishPending is high during the final write strobe, so DONE is
      // entered on the cycle after it.
      byteNext = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byteState <= S_WAIT_SYNC;
    end else begin
      byteState <= byteNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imemWE        <= 1'b0;
      imemAdrs      <= '0;
      imemWD        <= '0;
      error         <= 1'b0;
      lenLo         <= '0;
      lenWords      <= '0;
      wordIdx       <= '0;
      byteCnt       <= '0;
      wordBuf       <= '0;
      finishPending <= 1'b0;
    end else begin
      imemWE        <= 1'b0;
      finishPending <= 1'b0;
      if (frameErr) begin
        error   <= 1'b1;
        byteCnt <= '0;
      end
      if (byteValid) begin
        unique case (byteState)
          S_LEN_LO: lenLo <= rxByte;
          S_LEN_HI: begin
            lenWords <= lenFull;
            wordIdx  <= '0;
            byteCnt  <= '0;
            if ({1'b0, lenFull} > MAX_LEN)
              error <= 1'b1;
          end
          S_DATA: begin
            // Bytes enter at the top and slide down, so the first byte of
            // the word ends up in bits [7:0].
            wordBuf <= {rxByte, wordBuf[23:8]};
            byteCnt <= byteCnt + 1'b1;
            if (byteCnt == 2'd3) begin
              imemWE   <= 1'b1;
              imemAdrs <= {14'd0, wordIdx, 2'b00};
              imemWD   <= {rxByte, wordBuf};
              wordIdx  <= wordIdx + 1'b1;
              if (wordIdx == lenWords - 16'd1)
                finishPending <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign loading      = (byteState == S_LEN_LO) || (byteState == S_LEN_HI) ||
                        (byteState == S_DATA);
  assign done         = (byteState == S_DONE);
  assign coreReset    = (byteState != S_DONE);
  assign rxStateDbg   = rxState;
  assign byteStateDbg = byteState;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: drives UART bytes, predicts imem writes from
// the frame contents and compares them as the DUT strobes imemWE.
module tb_imem_uart_loader;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        imemWE;
  logic [31:0] imemAdrs;
  logic [31:0] imemWD;
  logic        coreReset;
  logic        loading;
  logic        done;
  logic        error;
  logic [1:0]  rxStateDbg;
  logic [2:0]  byteStateDbg;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .imemWE(imemWE), .imemAdrs(imemAdrs), .imemWD(imemWD),
    .coreReset(coreReset), .loading(loading), .done(done), .error(error),
    .rxStateDbg(rxStateDbg), .byteStateDbg(byteStateDbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  // {last word of frame, address, data}
  logic [64:0] exp_q[$];
  logic        chk_done_next = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] fw[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (chk_done_next) begin
      chk_done_next = 1'b0;
      check("done_after_last_write", {61'd0, done, coreReset, loading}, 64'b100);
    end
    if (imemWE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'd0, imemAdrs}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_adrs", {32'd0, imemAdrs}, {32'd0, e[63:32]});
        check("write_data", {32'd0, imemWD}, {32'd0, e[31:0]});
        if (e[64]) begin
          check("done_not_early", {63'd0, done}, 64'd0);
          chk_done_next = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    idle(3);
    reset = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(2 * CPB);
  endtask

  // Model: word i of an accepted frame is written to byte address 4*i.
  task automatic send_frame(input int len);
    logic [64:0] e;
    logic [15:0] l;
    l = 16'(len);
    for (int i = 0; i < len; i++) begin
      e[64]    = (i == len - 1);
      e[63:32] = 32'(i * 4);
      e[31:0]  = fw[i];
      exp_q.push_back(e);
    end
    send_byte(8'hA5);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
    for (int i = 0; i < len; i++)
      for (int k = 0; k < 4; k++)
        send_byte(8'(fw[i] >> (8 * k)));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(4);
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_loading);
    check(name, {60'd0, done, coreReset, loading, error},
          {60'd0, exp_done, !exp_done, exp_loading, exp_err});
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_flags"}, {59'd0, imemWE, coreReset, loading, done, error}, 64'b01000);
    check({name, "_bus"}, {imemAdrs, imemWD}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(3);
    reset = 1'b0;

    // 1: reset values, idle line
    check_reset_vals("reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {59'd0, imemWE, coreReset, loading, done, error}, 64'b01000);
    end

    // 2: two-word frame
    fw = '{32'h00100513, 32'h00200593};
    send_frame(2);
    wait_drain();
    check_status("t2_done", 1'b1, 1'b0);

    // 3: leading junk ignored, then one-cycle glitch
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(2);
    wait_drain();
    check_status("t3_done", 1'b1, 1'b0);
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(20);
    check_status("t3_glitch", 1'b1, 1'b0);

    // 4: framing error in DATA aborts the load
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    check_status("t4_loading", 1'b0, 1'b1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b0);
    exp_err = 1'b1;
    idle(10);
    check_status("t4_frame_err", 1'b0, 1'b0);
    fw = '{$urandom()};
    send_frame(1);
    wait_drain();
    check_status("t4_reload", 1'b1, 1'b0);

    // 5: length too large, then empty image
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    idle(4);
    check_status("t5_bad_len", 1'b0, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(4);
    check_status("t5_zero_len", 1'b1, 1'b0);

    // 6: reset mid-frame, reload, restart from DONE
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h05);
    do_reset();
    check_reset_vals("t6_reset");
    fw = '{32'h00100513, 32'h00200593};
    send_frame(2);
    wait_drain();
    check_status("t6_done", 1'b1, 1'b0);
    send_byte(8'hA5);
    idle(4);
    check_status("t6_restart", 1'b0, 1'b1);

    // randomized frames with junk prefixes and occasional bad lengths
    do_reset();
    for (int it = 0; it < 8; it++) begin
      int njunk;
      int len;
      logic [7:0] jb;
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h5A;
        send_byte(jb);
      end
      if ($urandom_range(0, 4) == 0) begin
        len = $urandom_range(1025, 3000);
        send_byte(8'hA5);
        send_byte(8'(len));
        send_byte(8'(len >> 8));
        exp_err = 1'b1;
        idle(4);
        check_status("rand_bad_len", 1'b0, 1'b0);
      end else begin
        len = $urandom_range(1, 3);
        fw.delete();
        for (int w = 0; w < len; w++) fw.push_back($urandom());
        send_frame(len);
        wait_drain();
        check_status("rand_done", 1'b1, 1'b0);
      end
    end

    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
